// File: rtl/aes_encrypt_iter_pkg.sv
// Shared AES definitions: round-count helpers, S-box table, GF(2^8) helpers,
// FSM state encoding. Byte 0 of a 128-bit block sits in bits [127:120] and
// bytes fill the state column by column (byte i -> row i%4, column i/4).
package aes_encrypt_iter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } fsm_state_e;

   function automatic bit key_bits_ok(input int key_bits);
      return (key_bits == 128) || (key_bits == 192) || (key_bits == 256);
   endfunction

   function automatic int nr_of(input int key_bits);
      case (key_bits)
         128:     return 10;
         192:     return 12;
         256:     return 14;
         default: return 10;
      endcase
   endfunction

   function automatic int ek_bits_of(input int key_bits);
      return (nr_of(key_bits) + 1) * 128;
   endfunction

   // Forward S-box, entry b at bits [8b +: 8]
   localparam logic [0:2047] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[{b, 3'b000} +: 8];
   endfunction

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One MixColumns column; byte 0 (row 0) in bits [31:24]
   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes_encrypt_iter_if.sv
// Job/result handshake bundle between key-expansion producer, encryptor and
// cipher consumer. The slave modport is the encryptor side.
interface aes_encrypt_iter_if #(
   parameter int KEY_BITS = 128
);
   import aes_encrypt_iter_pkg::*;

   localparam int EK_BITS = ek_bits_of(KEY_BITS);

   logic                 in_valid;
   logic                 in_ready;
   logic [127:0]         plain_text;
   logic [0:EK_BITS-1]   expanded_key;
   logic                 out_valid;
   logic                 out_ready;
   logic [127:0]         cipher;
   logic                 busy;

   modport master (
      output in_valid, plain_text, expanded_key, out_ready,
      input  in_ready, out_valid, cipher, busy
   );

   modport slave (
      input  in_valid, plain_text, expanded_key, out_ready,
      output in_ready, out_valid, cipher, busy
   );

endinterface

// File: rtl/aes_encrypt_iter_round_unit.sv
// One AES encryption round, purely combinational:
// SubBytes -> ShiftRows -> MixColumns (skipped on the final round) -> AddRoundKey.
module aes_encrypt_iter_round_unit
   import aes_encrypt_iter_pkg::*;
(
   input  logic [127:0] state_i,
   input  logic [127:0] round_key_i,
   input  logic         final_rnd_i,
   output logic [127:0] next_state_o
);

   logic [7:0] sb_s [16];
   logic [7:0] sr_s [16];
   logic [7:0] mc_s [16];

   // SubBytes on every state byte
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         sb_s[i] = sbox(state_i[127-8*i -: 8]);
      end
   end

   // ShiftRows: row r rotates left by r columns
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr_s[4*c+r] = sb_s[4*((c+r)%4)+r];
         end
      end
   end

   // MixColumns per column
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         {mc_s[4*c], mc_s[4*c+1], mc_s[4*c+2], mc_s[4*c+3]} =
            mix_col({sr_s[4*c], sr_s[4*c+1], sr_s[4*c+2], sr_s[4*c+3]});
      end
   end

   // AddRoundKey, bypassing MixColumns on the last round
   always_comb begin
      next_state_o = 128'd0;
      for (int i = 0; i < 16; i++) begin
         next_state_o[127-8*i -: 8] = (final_rnd_i ? sr_s[i] : mc_s[i]) ^ round_key_i[127-8*i -: 8];
      end
   end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryptor: one round per clock through a shared round unit.
// Round keys 1..NR are latched at accept; key 0 is applied on the accept edge.
module aes_encrypt_iter
   import aes_encrypt_iter_pkg::*;
#(
   parameter int KEY_BITS = 128
)
(
   input  logic              clk,
   input  logic              rst_n,
   aes_encrypt_iter_if.slave bus
);

   localparam int NR      = nr_of(KEY_BITS);
   localparam int EK_BITS = (NR + 1) * 128;
   localparam int RND_W   = $clog2(NR + 1);
   localparam logic [RND_W-1:0] NR_L = RND_W'(NR);

   if (!key_bits_ok(KEY_BITS)) begin : g_bad_key_bits
      $error("aes_encrypt_iter: KEY_BITS must be 128, 192 or 256");
   end

   fsm_state_e              fsm_q;
   logic [RND_W-1:0]        rnd_q;
   logic [RND_W-1:0]        rnd_d;
   logic [RND_W-1:0]        rnd_m1_s;
   logic [127:0]            state_q;
   logic [127:0]            state_d;
   logic [127:0]            cipher_q;
   logic [127:0]            round_key_s;
   logic [0:EK_BITS-129]    key_q;
   logic                    in_ready_q;
   logic                    out_valid_q;
   logic                    busy_q;
   logic                    final_rnd_s;
   logic                    rnd_ok_s;

   // Round counter decode and round-key selection
   always_comb begin
      rnd_d       = rnd_q + RND_W'(1);
      rnd_m1_s    = rnd_q - RND_W'(1);
      final_rnd_s = (rnd_q == NR_L);
      rnd_ok_s    = (rnd_q != '0) && (rnd_q <= NR_L);
      if (rnd_ok_s) begin
         round_key_s = key_q[{rnd_m1_s, 7'd0} +: 128];
      end else begin
         round_key_s = 128'd0;
      end
   end

   aes_encrypt_iter_round_unit u_round (
      .state_i      (state_q),
      .round_key_i  (round_key_s),
      .final_rnd_i  (final_rnd_s),
      .next_state_o (state_d)
   );

   // Control FSM, round counter, key latch and state/cipher registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= ST_IDLE;
         rnd_q       <= '0;
         state_q     <= 128'd0;
         cipher_q    <= 128'd0;
         key_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (fsm_q)
            ST_IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  state_q    <= bus.plain_text ^ bus.expanded_key[0 +: 128];
                  key_q      <= bus.expanded_key[128 +: EK_BITS-128];
                  rnd_q      <= RND_W'(1);
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  fsm_q      <= ST_RUN;
               end else begin
                  rnd_q       <= '0;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            ST_RUN: begin
               if (!rnd_ok_s) begin
                  // Corrupted counter: drop the job, never present partial data
                  fsm_q       <= ST_IDLE;
                  rnd_q       <= '0;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end else if (final_rnd_s) begin
                  cipher_q    <= state_d;
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
                  rnd_q       <= '0;
                  fsm_q       <= ST_DONE;
               end else begin
                  state_q <= state_d;
                  rnd_q   <= rnd_d;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  fsm_q       <= ST_IDLE;
               end else begin
                  out_valid_q <= 1'b1;
               end
            end
            default: begin
               fsm_q       <= ST_IDLE;
               rnd_q       <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.cipher    = cipher_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: three instances (AES-128/192/256), a reference
// model built from a computed S-box, and a per-instance scoreboard checked by
// a monitor that samples just after each falling edge.
module tb_aes_encrypt_iter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   aes_encrypt_iter_if #(.KEY_BITS(128)) if128 ();
   aes_encrypt_iter_if #(.KEY_BITS(192)) if192 ();
   aes_encrypt_iter_if #(.KEY_BITS(256)) if256 ();

   aes_encrypt_iter #(.KEY_BITS(128)) dut128 (.clk(clk), .rst_n(rst_n), .bus(if128));
   aes_encrypt_iter #(.KEY_BITS(192)) dut192 (.clk(clk), .rst_n(rst_n), .bus(if192));
   aes_encrypt_iter #(.KEY_BITS(256)) dut256 (.clk(clk), .rst_n(rst_n), .bus(if256));

   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

   int           n_checks = 0;
   int           n_errors = 0;
   int           cyc = 0;
   logic [7:0]   sbox_t [256];
   logic [127:0] exp_q [3][$];
   int           acc_edge [3];
   int           last_rise [3];
   int           n_spur [3];
   logic         ov_prev [3];
   logic         hold_prev [3];
   logic [127:0] c_prev [3];
   bit           spacing_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   // S-box from multiplicative inverse plus affine transform
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_t[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   function automatic logic [0:1919] key_expand(input logic [0:255] key, input int nk);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      logic [0:1919] ek;
      rc = 8'h01;
      ek = '0;
      for (int i = 0; i < 4 * (nk + 7); i++) begin
         if (i < nk) begin
            w[i] = key[32*i +: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
               rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
               t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
         end
         ek[32*i +: 32] = w[i];
      end
      return ek;
   endfunction

   function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [0:1919] ek, input int nr);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] r;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ek[8*i +: 8];
      for (int rd = 1; rd <= nr; rd++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i + 4*(i%4)) % 16]];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (rd < nr) begin
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ ek[128*rd + 8*i +: 8];
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
      return r;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   task automatic mon_step(input int idx, input logic iv, input logic ir, input logic ov,
                           input logic ordy, input logic [127:0] c);
      if (!rst_n) begin
         ov_prev[idx]   = 1'b0;
         hold_prev[idx] = 1'b0;
         acc_edge[idx]  = -1;
         last_rise[idx] = -1;
      end else begin
         if (hold_prev[idx]) begin
            chk($sformatf("hold_valid%0d", idx), 128'(ov), 128'(1'b1));
            chk($sformatf("hold_cipher%0d", idx), c, c_prev[idx]);
         end
         if (ov && !ov_prev[idx]) begin
            chk($sformatf("latency%0d", idx), 128'(cyc - acc_edge[idx]), 128'(10 + 2*idx));
            if (spacing_on && idx == 0 && last_rise[0] >= 0)
               chk("spacing", 128'(cyc - last_rise[0]), 128'(12));
            last_rise[idx] = cyc;
         end
         if (ov && ordy) begin
            if (exp_q[idx].size() == 0) n_spur[idx]++;
            else chk($sformatf("cipher%0d", idx), c, exp_q[idx].pop_front());
         end
         if (iv && ir) acc_edge[idx] = cyc + 1;
         ov_prev[idx]   = ov;
         hold_prev[idx] = ov && !ordy;
         c_prev[idx]    = c;
      end
   endtask

   always @(negedge clk) begin
      #1 mon_step(0, if128.in_valid, if128.in_ready, if128.out_valid, if128.out_ready, if128.cipher);
   end
   always @(negedge clk) begin
      #1 mon_step(1, if192.in_valid, if192.in_ready, if192.out_valid, if192.out_ready, if192.cipher);
   end
   always @(negedge clk) begin
      #1 mon_step(2, if256.in_valid, if256.in_ready, if256.out_valid, if256.out_ready, if256.cipher);
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input int idx, input logic v, input logic [127:0] pt, input logic [0:1919] ek);
      case (idx)
         0: begin if128.in_valid = v; if128.plain_text = pt; if128.expanded_key = ek[0 +: 1408]; end
         1: begin if192.in_valid = v; if192.plain_text = pt; if192.expanded_key = ek[0 +: 1664]; end
         default: begin if256.in_valid = v; if256.plain_text = pt; if256.expanded_key = ek[0 +: 1920]; end
      endcase
   endtask

   function automatic logic get_ready(input int idx);
      case (idx)
         0:       return if128.in_ready;
         1:       return if192.in_ready;
         default: return if256.in_ready;
      endcase
   endfunction

   // Present a job, push its expected cipher, return on the falling edge after acceptance
   task automatic send(input int idx, input logic [127:0] pt, input logic [0:1919] ek,
                       input logic [127:0] expc, input bit hold);
      int n;
      @(negedge clk);
      drive(idx, 1'b1, pt, ek);
      exp_q[idx].push_back(expc);
      n = 0;
      while (!get_ready(idx) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk($sformatf("accept_timeout%0d", idx), 128'(get_ready(idx)), 128'(1'b1));
      @(negedge clk);
      if (!hold) drive(idx, 1'b0, pt, ek);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 128'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 128'(0));
      @(negedge clk);
   endtask

   function automatic logic [0:1919] rand_bits();
      logic [0:1919] r;
      for (int w = 0; w < 60; w++) r[32*w +: 32] = $urandom();
      return r;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic [0:1919] ek128, ek192, ek256, ekr;
      logic [127:0]  ptr;
      logic [0:255]  keyr;
      int            n;

      build_sbox();
      for (int i = 0; i < 3; i++) n_spur[i] = 0;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) drive(i, 1'b0, 128'd0, '0);
      if128.out_ready = 1'b1;
      if192.out_ready = 1'b1;
      if256.out_ready = 1'b1;
      ek128 = key_expand({128'h000102030405060708090a0b0c0d0e0f, 128'd0}, 4);
      ek192 = key_expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'd0}, 6);
      ek256 = key_expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", 128'(if128.in_ready), 128'(1'b1));
      chk("rst_out_valid", 128'(if128.out_valid), 128'(1'b0));
      chk("rst_busy", 128'(if128.busy), 128'(1'b0));
      chk("rst_cipher", if128.cipher, 128'd0);
      chk("rst_in_ready192", 128'(if192.in_ready), 128'(1'b1));
      chk("rst_out_valid256", 128'(if256.out_valid), 128'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;

      // FIPS-197 vectors on all three key sizes
      send(0, PT, ek128, C128, 1'b0);
      send(1, PT, ek192, C192, 1'b0);
      send(2, PT, ek256, C256, 1'b0);
      #1;
      chk("run_busy", 128'(if128.busy), 128'(1'b1));
      chk("run_in_ready", 128'(if128.in_ready), 128'(1'b0));
      chk("run_out_valid", 128'(if128.out_valid), 128'(1'b0));
      chk("run_busy256", 128'(if256.busy), 128'(1'b1));
      drain(100);

      // Backpressure: result held while inputs churn
      if128.out_ready = 1'b0;
      send(0, PT, ek128, C128, 1'b0);
      n = 0;
      while (!if128.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_out_valid", 128'(if128.out_valid), 128'(1'b1));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(0, 1'($urandom_range(1)), {$urandom(), $urandom(), $urandom(), $urandom()}, rand_bits());
         #1;
         chk("bp_in_ready", 128'(if128.in_ready), 128'(1'b0));
         chk("bp_busy", 128'(if128.busy), 128'(1'b0));
      end
      @(negedge clk);
      drive(0, 1'b0, 128'd0, '0);
      if128.out_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_idle_in_ready", 128'(if128.in_ready), 128'(1'b1));
      chk("bp_idle_out_valid", 128'(if128.out_valid), 128'(1'b0));

      // Back-to-back random blocks with in_valid held high
      spacing_on = 1'b1;
      last_rise[0] = -1;
      for (int b = 0; b < 3; b++) begin
         ptr  = {$urandom(), $urandom(), $urandom(), $urandom()};
         keyr = {$urandom(), $urandom(), $urandom(), $urandom(), 128'd0};
         ekr  = key_expand(keyr, 4);
         send(0, ptr, ekr, aes_model(ptr, ekr, 10), b < 2);
      end
      drain(100);
      spacing_on = 1'b0;

      // Reset in the middle of a job
      send(0, PT, ek128, C128, 1'b0);
      repeat (4) @(negedge clk);
      exp_q[0].delete();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 128'(if128.out_valid), 128'(1'b0));
      chk("mid_rst_busy", 128'(if128.busy), 128'(1'b0));
      chk("mid_rst_in_ready", 128'(if128.in_ready), 128'(1'b1));
      chk("mid_rst_cipher", if128.cipher, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(0, PT, ek128, C128, 1'b0);
      drain(100);

      for (int i = 0; i < 3; i++) chk($sformatf("spurious_out%0d", i), 128'(n_spur[i]), 128'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
